i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one `i2c_master` instance between `NUMBER_OF_REQUESTERS` independent clients (e.g. sensor poller, config loader, host bridge). It latches one requester's transaction fields, drives the master's `enable` handshake, and tracks `busy` to completion. It returns read data plus a one-cycle `done` (or `error` on timeout) to the owning requester. It sits directly between the clients and the `i2c_master` command port.

## Interface
- `NUMBER_OF_REQUESTERS`, 2: client count, 2..8.
- `DATA_WIDTH`, 8: per-transaction data width; matches `i2c_master` `NUMBER_OF_DATA_BYTES*8`.
- `REGISTER_WIDTH`, 8: register address width.
- `ADDRESS_WIDTH`, 7: device address width.
- `TIMEOUT_WIDTH`, 20: watchdog counter width.
- `START_TIMEOUT`, 'hFF: max cycles from `enable` to `busy` rising.
- `TRANSFER_TIMEOUT`, 'hF_FFFF: max cycles `busy` may stay high.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `request` in N: per-client request level; held until own `done`/`error`.
- `read_write` in N: per-client 1 = read, 0 = write.
- `mosi_data` in N*DATA_WIDTH: client k at slice [k*DATA_WIDTH +: DATA_WIDTH]; same packing for the next two.
- `register_address` in N*REGISTER_WIDTH.
- `device_address` in N*ADDRESS_WIDTH.
- `grant` out N: one-hot owner; zero when idle.
- `done` out N: one-cycle completion pulse to owner.
- `error` out N: one-cycle timeout pulse to owner.
- `miso_data` out DATA_WIDTH: read data; valid with `done`, held until next completion.
- `master_enable` out 1: drives `i2c_master.enable`.
- `master_read_write` out 1; `master_mosi_data` out DATA_WIDTH; `master_register_address` out REGISTER_WIDTH; `master_device_address` out ADDRESS_WIDTH: latched command.
- `master_reset_n` out 1: drives `i2c_master.reset_n`.
- `master_busy` in 1; `master_miso_data` in DATA_WIDTH: from `i2c_master`.

## Operation
- FSM states: IDLE, LAUNCH, TRANSFER, COMPLETE, FAULT.
- **IDLE**: if any `request` is set, pick the first set bit at or after `priority_pointer`, wrapping modulo N.
  - Latch that client's fields into `master_*` registers.
  - Set `grant`, go to LAUNCH.
- **LAUNCH**: `master_enable`=1; watchdog counts.
  - `master_busy`=1 → drop enable, clear watchdog, go to TRANSFER.
  - Watchdog = START_TIMEOUT → FAULT.
- **TRANSFER**: `master_enable`=0.
  - `master_busy`=0 → capture `master_miso_data` into `miso_data` (reads only; writes leave it unchanged), go to COMPLETE.
  - Watchdog = TRANSFER_TIMEOUT → FAULT.
- **COMPLETE**: pulse `done[owner]`, clear `grant`, set `priority_pointer` = owner+1 mod N, go to IDLE.
- **FAULT**: pulse `error[owner]`, hold `master_reset_n`=0 for this one cycle to recover the master, clear `grant`, advance pointer, go to IDLE.
- Latched fields are frozen from grant to COMPLETE/FAULT. Client input changes mid-transaction are ignored.
- Dropping `request` mid-transaction does not abort. Completion is still signalled.
- A request that is not granted has no effect and stays pending.

## Timing
- Reset values: `grant`, `done`, `error`, `master_enable`, `master_*` fields, `miso_data` = 0; `master_reset_n` = 0 during reset, 1 after; `priority_pointer` = 0; state = IDLE.
- `request` sampled in IDLE at cycle T → `grant` and `master_enable` high at T+1.
- `done` asserts 1 cycle after `master_busy` is sampled low in TRANSFER.
- Minimum gap `done` → next `grant`: 2 cycles (COMPLETE, IDLE). `request` still high in COMPLETE is re-arbitrated in IDLE.
- Simultaneous requests: strict rotation, so each client waits at most N−1 transactions.
- Watchdog is a TIMEOUT_WIDTH saturating counter, cleared on every state change.
- `reset` mid-transaction: immediate return to IDLE, all outputs to reset values, no `done`/`error`.

## Structure
- Package `i2c_master_arbiter_pkg`: state enum, default timeout constants.
- Sub-module `round_robin_selector` (combinational N-bit request + pointer → one-hot and index). This is the only natural split.
- The rest is a single FSM module.

## Test plan
- Single client 0 write (dev 0x11, reg 0x05, data 0xA5): `grant`=01 one cycle after request; `master_enable` high until `busy`; `done[0]` once; slave reg 0x05 = 0xA5.
- Client 1 read (dev 0x41, reg 0x05) after a write of 0x3C: `done[1]` with `miso_data`=0x3C; `done[0]` never pulses.
- Both clients request in the same cycle, pointer=0: client 0 served first, then client 1 with no extra arbitration gap; a re-request from 0 is served after 1.
- Device that never drives busy (`master_busy` tied 0): `error[owner]` after 0xFF+2 cycles; `master_reset_n` low one cycle; the next request is served normally.
- `reset` asserted mid-TRANSFER: next cycle `grant`=0, `master_enable`=0, no `done`/`error`, pointer=0.

Source files
------------

// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and default watchdog limits for the i2c_master arbiter.
package i2c_master_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_TRANSFER,
        ST_COMPLETE,
        ST_FAULT
    } arbiter_state_t;

    localparam int          DEFAULT_TIMEOUT_WIDTH    = 20;
    localparam logic [19:0] DEFAULT_START_TIMEOUT    = 20'h000FF;
    localparam logic [19:0] DEFAULT_TRANSFER_TIMEOUT = 20'hFFFFF;

endpackage

// File: rtl/i2c_master_arbiter_selector.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module round_robin_selector #(
    parameter int NUMBER_OF_REQUESTERS = 2,
    parameter int INDEX_WIDTH          = $clog2(NUMBER_OF_REQUESTERS)
) (
    input  logic [NUMBER_OF_REQUESTERS-1:0] request,
    input  logic [INDEX_WIDTH-1:0]          priority_pointer,
    output logic [NUMBER_OF_REQUESTERS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0]          index,
    output logic                            valid
);

    // Scan from farthest to nearest so the closest candidate to the pointer wins.
    always_comb begin
        one_hot = '0;
        index   = '0;
        valid   = 1'b0;
        for (int k = NUMBER_OF_REQUESTERS - 1; k >= 0; k--) begin
            if (request[(int'(priority_pointer) + k) % NUMBER_OF_REQUESTERS]) begin
                valid          = 1'b1;
                index          = INDEX_WIDTH'((int'(priority_pointer) + k) % NUMBER_OF_REQUESTERS);
                one_hot        = '0;
                one_hot[index] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between several clients: round-robin grant, command latch, watchdog.
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int NUMBER_OF_REQUESTERS = 2,
    parameter int DATA_WIDTH           = 8,
    parameter int REGISTER_WIDTH       = 8,
    parameter int ADDRESS_WIDTH        = 7,
    parameter int TIMEOUT_WIDTH        = DEFAULT_TIMEOUT_WIDTH,
    parameter logic [TIMEOUT_WIDTH-1:0] START_TIMEOUT    = TIMEOUT_WIDTH'(DEFAULT_START_TIMEOUT),
    parameter logic [TIMEOUT_WIDTH-1:0] TRANSFER_TIMEOUT = TIMEOUT_WIDTH'(DEFAULT_TRANSFER_TIMEOUT)
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [NUMBER_OF_REQUESTERS-1:0]            request,
    input  logic [NUMBER_OF_REQUESTERS-1:0]            read_write,
    input  logic [NUMBER_OF_REQUESTERS*DATA_WIDTH-1:0] mosi_data,
    input  logic [NUMBER_OF_REQUESTERS*REGISTER_WIDTH-1:0] register_address,
    input  logic [NUMBER_OF_REQUESTERS*ADDRESS_WIDTH-1:0]  device_address,
    output logic [NUMBER_OF_REQUESTERS-1:0]            grant,
    output logic [NUMBER_OF_REQUESTERS-1:0]            done,
    output logic [NUMBER_OF_REQUESTERS-1:0]            error,
    output logic [DATA_WIDTH-1:0]                      miso_data,
    output logic                                       master_enable,
    output logic                                       master_read_write,
    output logic [DATA_WIDTH-1:0]                      master_mosi_data,
    output logic [REGISTER_WIDTH-1:0]                  master_register_address,
    output logic [ADDRESS_WIDTH-1:0]                   master_device_address,
    output logic                                       master_reset_n,
    input  logic                                       master_busy,
    input  logic [DATA_WIDTH-1:0]                      master_miso_data
);

    localparam int INDEX_WIDTH = $clog2(NUMBER_OF_REQUESTERS);

    arbiter_state_t                state, next_state;
    logic [INDEX_WIDTH-1:0]        priority_pointer, owner, next_pointer;
    logic [TIMEOUT_WIDTH-1:0]      watchdog;
    logic [NUMBER_OF_REQUESTERS-1:0] select_one_hot;
    logic [INDEX_WIDTH-1:0]        select_index;
    logic                          select_valid;

    round_robin_selector #(
        .NUMBER_OF_REQUESTERS(NUMBER_OF_REQUESTERS),
        .INDEX_WIDTH         (INDEX_WIDTH)
    ) selector (
        .request         (request),
        .priority_pointer(priority_pointer),
        .one_hot         (select_one_hot),
        .index           (select_index),
        .valid           (select_valid)
    );

    assign next_pointer  = (owner == INDEX_WIDTH'(NUMBER_OF_REQUESTERS - 1)) ? '0 : owner + 1'b1;
    assign master_enable = (state == ST_LAUNCH);
    assign done          = (state == ST_COMPLETE) ? grant : '0;
    assign error         = (state == ST_FAULT)    ? grant : '0;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (select_valid) next_state = ST_LAUNCH;
            ST_LAUNCH: begin
                if (master_busy)                    next_state = ST_TRANSFER;
                else if (watchdog == START_TIMEOUT) next_state = ST_FAULT;
            end
            ST_TRANSFER: begin
                if (!master_busy)                      next_state = ST_COMPLETE;
                else if (watchdog == TRANSFER_TIMEOUT) next_state = ST_FAULT;
            end
            default:     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= ST_IDLE;
            grant                   <= '0;
            owner                   <= '0;
            priority_pointer        <= '0;
            watchdog                <= '0;
            miso_data               <= '0;
            master_read_write       <= 1'b0;
            master_mosi_data        <= '0;
            master_register_address <= '0;
            master_device_address   <= '0;
            master_reset_n          <= 1'b0;
        end else begin
            state          <= next_state;
            // The master is held in reset for exactly the FAULT cycle.
            master_reset_n <= (next_state != ST_FAULT);
            if (next_state != state)  watchdog <= '0;
            else if (watchdog != '1)  watchdog <= watchdog + 1'b1;
            case (state)
                ST_IDLE: if (select_valid) begin
                    grant                   <= select_one_hot;
                    owner                   <= select_index;
                    master_read_write       <= read_write[select_index];
                    master_mosi_data        <= mosi_data[select_index*DATA_WIDTH +: DATA_WIDTH];
                    master_register_address <= register_address[select_index*REGISTER_WIDTH +: REGISTER_WIDTH];
                    master_device_address   <= device_address[select_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                end
                ST_TRANSFER: if (!master_busy && master_read_write) miso_data <= master_miso_data;
                ST_COMPLETE, ST_FAULT: begin
                    grant            <= '0;
                    priority_pointer <= next_pointer;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed + randomized checks of the arbiter against a transaction-level model and a slave stub.
module tb_i2c_master_arbiter;
    localparam int N = 3, DW = 8, RW = 8, AW = 7, TW = 20;
    localparam logic [TW-1:0] START_TO = 20'h000FF;
    localparam logic [TW-1:0] XFER_TO  = 20'h00040;

    logic clock = 1'b0;
    logic reset;
    logic [N-1:0] request, read_write, grant, done, error;
    logic [N*DW-1:0] mosi_data;
    logic [N*RW-1:0] register_address;
    logic [N*AW-1:0] device_address;
    logic [DW-1:0] miso_data, master_mosi_data;
    logic [DW-1:0] master_miso_data = '0;
    logic master_enable, master_read_write, master_reset_n;
    logic master_busy = 1'b0;
    logic [RW-1:0] master_register_address;
    logic [AW-1:0] master_device_address;

    always #5 clock = ~clock;

    i2c_master_arbiter #(
        .NUMBER_OF_REQUESTERS(N), .DATA_WIDTH(DW), .REGISTER_WIDTH(RW), .ADDRESS_WIDTH(AW),
        .TIMEOUT_WIDTH(TW), .START_TIMEOUT(START_TO), .TRANSFER_TIMEOUT(XFER_TO)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .read_write(read_write),
        .mosi_data(mosi_data), .register_address(register_address), .device_address(device_address),
        .grant(grant), .done(done), .error(error), .miso_data(miso_data),
        .master_enable(master_enable), .master_read_write(master_read_write),
        .master_mosi_data(master_mosi_data), .master_register_address(master_register_address),
        .master_device_address(master_device_address), .master_reset_n(master_reset_n),
        .master_busy(master_busy), .master_miso_data(master_miso_data)
    );

    int vectors = 0, miscompares = 0;

    // Slave-side stand-in for i2c_master: mode 0 normal, 1 never busy, 2 busy forever.
    int stub_mode = 0, phase = 0, cnt = 0;
    bit [7:0] slave_mem [0:32767];
    always @(posedge clock) begin
        if (reset || !master_reset_n) begin
            phase = 0;
            master_busy <= 1'b0;
        end else begin
            case (phase)
                0: if (master_enable && stub_mode != 1) begin phase = 1; cnt = $urandom_range(0, 3); end
                1: if (cnt == 0) begin master_busy <= 1'b1; phase = 2; cnt = $urandom_range(1, 6); end
                   else cnt--;
                2: if (stub_mode != 2) begin
                       if (cnt == 0) begin
                           master_busy <= 1'b0;
                           phase = 0;
                           if (master_read_write)
                               master_miso_data <= slave_mem[{master_device_address, master_register_address}];
                           else
                               slave_mem[{master_device_address, master_register_address}] = master_mosi_data;
                       end else cnt--;
                   end
                default: phase = 0;
            endcase
        end
    end

    // Reference model: what each client asked for, device memory, rotation pointer.
    bit       c_rw   [N];
    bit [6:0] c_dev  [N];
    bit [7:0] c_reg  [N];
    bit [7:0] c_data [N];
    bit [7:0] ref_mem [0:32767];
    bit [7:0] ref_miso = 8'h00;
    int       ref_ptr = 0;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_client(input int k, input bit rw, input bit [6:0] dev, input bit [7:0] rg, input bit [7:0] d);
        c_rw[k] = rw; c_dev[k] = dev; c_reg[k] = rg; c_data[k] = d;
        read_write[k] = rw;
        mosi_data[k*DW +: DW] = d;
        register_address[k*RW +: RW] = rg;
        device_address[k*AW +: AW] = dev;
    endtask

    task automatic scramble(input int k);
        read_write[k] = 1'($urandom);
        mosi_data[k*DW +: DW] = 8'($urandom);
        register_address[k*RW +: RW] = 8'($urandom);
        device_address[k*AW +: AW] = 7'($urandom);
    endtask

    // Entered at a negedge; returns at the negedge of the done/error cycle.
    task automatic serve(input int k, input int exp_wait, input bit drop_early);
        int w;
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[k] = 1'b1;
        w = 0;
        do begin @(negedge clock); w++; end while (grant == '0 && w < 50);
        check("grant_latency", w, exp_wait);
        check("grant_owner", grant, onehot);
        check("enable_at_grant", master_enable, 1'b1);
        check("latched_cmd", {master_read_write, master_device_address, master_register_address, master_mosi_data},
              {c_rw[k], c_dev[k], c_reg[k], c_data[k]});
        scramble(k);
        if (drop_early) request[k] = 1'b0;
        w = 0;
        do begin @(negedge clock); w++; end while ((done | error) == '0 && w < 200);
        check("done_owner", done, onehot);
        check("no_error", error, '0);
        if (c_rw[k]) ref_miso = ref_mem[{c_dev[k], c_reg[k]}];
        else         ref_mem[{c_dev[k], c_reg[k]}] = c_data[k];
        check("miso_data", miso_data, ref_miso);
        request[k] = 1'b0;
        ref_ptr = (k + 1) % N;
    endtask

    initial begin
        int w, k, guard;
        bit first;
        logic [N-1:0] mask, onehot;
        bit [6:0] devs [3];
        devs = '{7'h11, 7'h41, 7'h22};

        reset = 1'b1; request = '0; read_write = '0;
        mosi_data = '0; register_address = '0; device_address = '0;
        repeat (3) @(negedge clock);
        check("rst_grant", grant, '0);
        check("rst_done_error", {done, error}, '0);
        check("rst_enable", master_enable, 1'b0);
        check("rst_fields", {master_read_write, master_device_address, master_register_address, master_mosi_data}, '0);
        check("rst_miso", miso_data, '0);
        check("rst_master_reset_n", master_reset_n, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_master_reset_n", master_reset_n, 1'b1);

        // Single client 0 write
        set_client(0, 1'b0, 7'h11, 8'h05, 8'hA5);
        request[0] = 1'b1;
        serve(0, 1, 1'b0);
        check("slave_reg_a5", slave_mem[{7'h11, 8'h05}], 8'hA5);
        @(negedge clock);
        check("done_single_pulse", done, '0);
        check("grant_cleared", grant, '0);

        // Write 0x3C then client 1 reads it back
        set_client(0, 1'b0, 7'h41, 8'h05, 8'h3C);
        request[0] = 1'b1;
        serve(pick(request, ref_ptr), 1, 1'b0);
        set_client(1, 1'b1, 7'h41, 8'h05, 8'h00);
        request[1] = 1'b1;
        serve(pick(request, ref_ptr), 2, 1'b0);
        check("read_back_3c", miso_data, 8'h3C);

        // Client 2 moves the pointer to 0, then 0 and 1 collide; 0 re-requests during 1
        set_client(2, 1'b0, 7'h22, 8'h01, 8'h5A);
        request[2] = 1'b1;
        serve(pick(request, ref_ptr), 2, 1'b0);
        @(negedge clock);
        set_client(0, 1'b0, 7'h22, 8'h02, 8'h77);
        set_client(1, 1'b1, 7'h22, 8'h01, 8'h00);
        request[1:0] = 2'b11;
        check("collide_pick0", pick(request, ref_ptr), 0);
        serve(0, 1, 1'b0);
        set_client(0, 1'b1, 7'h22, 8'h02, 8'h00);
        request[0] = 1'b1;
        serve(pick(request, ref_ptr), 2, 1'b0);
        serve(pick(request, ref_ptr), 2, 1'b0);

        // Device never drives busy: start watchdog fires
        @(negedge clock);
        stub_mode = 1;
        k = ref_ptr;
        onehot = '0; onehot[k] = 1'b1;
        set_client(k, 1'b0, 7'h11, 8'h09, 8'hEE);
        request[k] = 1'b1;
        w = 0;
        do begin @(negedge clock); w++; end while (error == '0 && w < 600);
        check("start_timeout_cycles", w, START_TO + 2);
        check("start_timeout_error", error, onehot);
        check("start_timeout_no_done", done, '0);
        check("fault_master_reset_n", master_reset_n, 1'b0);
        stub_mode = 0;
        request[k] = 1'b0;
        ref_ptr = (k + 1) % N;
        @(negedge clock);
        check("fault_recover_reset_n", master_reset_n, 1'b1);
        check("fault_error_pulse", error, '0);
        k = ref_ptr;
        set_client(k, 1'b0, 7'h11, 8'h0A, 8'h42);
        request[k] = 1'b1;
        serve(k, 1, 1'b0);

        // Busy never falls: transfer watchdog fires
        @(negedge clock);
        stub_mode = 2;
        k = ref_ptr;
        onehot = '0; onehot[k] = 1'b1;
        set_client(k, 1'b0, 7'h41, 8'h07, 8'h99);
        request[k] = 1'b1;
        w = 0;
        do begin @(negedge clock); w++; end while (grant == '0 && w < 20);
        check("xfer_grant_wait", w, 1);
        w = 0;
        while (master_enable && w < 50) begin @(negedge clock); w++; end
        w = 0;
        do begin @(negedge clock); w++; end while (error == '0 && w < 300);
        check("xfer_timeout_cycles", w, XFER_TO + 1);
        check("xfer_timeout_error", error, onehot);
        check("xfer_timeout_no_done", done, '0);
        stub_mode = 0;
        request[k] = 1'b0;
        ref_ptr = (k + 1) % N;

        // Normal transaction, then reset in the middle of a stuck transfer
        @(negedge clock);
        k = ref_ptr;
        set_client(k, 1'b0, 7'h22, 8'h03, 8'h13);
        request[k] = 1'b1;
        serve(k, 1, 1'b0);
        @(negedge clock);
        stub_mode = 2;
        k = ref_ptr;
        set_client(k, 1'b0, 7'h22, 8'h04, 8'h66);
        request[k] = 1'b1;
        w = 0;
        do begin @(negedge clock); w++; end while (grant == '0 && w < 20);
        w = 0;
        while (master_enable && w < 50) begin @(negedge clock); w++; end
        reset = 1'b1;
        request = '0;
        stub_mode = 0;
        @(negedge clock);
        check("midrst_grant", grant, '0);
        check("midrst_enable", master_enable, 1'b0);
        check("midrst_done_error", {done, error}, '0);
        check("midrst_miso", miso_data, '0);
        reset = 1'b0;
        ref_ptr = 0;
        ref_miso = 8'h00;
        @(negedge clock);
        set_client(0, 1'b1, 7'h22, 8'h03, 8'h00);
        set_client(2, 1'b1, 7'h11, 8'h0A, 8'h00);
        request = 3'b101;
        serve(0, 1, 1'b0);
        serve(pick(request, ref_ptr), 2, 1'b0);

        // Randomized request mixes against the rotation model
        @(negedge clock);
        for (int it = 0; it < 25; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int c = 0; c < N; c++)
                if (mask[c])
                    set_client(c, 1'($urandom), devs[$urandom_range(0, 2)], 8'($urandom_range(0, 3)), 8'($urandom));
            request = mask;
            first = 1'b1;
            guard = 0;
            while (request != '0 && guard < 10) begin
                serve(pick(request, ref_ptr), first ? 1 : 2, $urandom_range(0, 3) == 0);
                first = 1'b0;
                guard++;
            end
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
